mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-read/single-write mem block between three requesters:
//   CPU (read+write, incl. GPU traffic it muxes), screen refresh reader
//   (read-only), program loader (write-only, ROM/UART upload). Sits between
//   cpu/loader/display logic and mem; one transaction in flight at a time.
// PARAMETERS
//   ADDR_W      12  memory index width
//   DATA_W      8   memory data width
//   GRANT_TMO   15  max BUSY cycles awaiting mem_read_ack before abort (1..255)
// PORTS
//   clk            in   1       system clock; all logic on posedge
//   reset          in   1       synchronous, active-high reset
//   cpu_rd         in   1       CPU read request, held until cpu_ack
//   cpu_wr         in   1       CPU write request, held until cpu_ack
//   cpu_idx        in   ADDR_W  CPU address
//   cpu_wbyte      in   DATA_W  CPU write data
//   cpu_rbyte      out  DATA_W  CPU read data, valid when cpu_ack after read
//   cpu_ack        out  1       1-cycle completion pulse to CPU
//   scr_rd         in   1       screen read request, held until scr_ack
//   scr_idx        in   ADDR_W  screen address
//   scr_rbyte      out  DATA_W  screen read data, valid with scr_ack
//   scr_ack        out  1       1-cycle completion pulse to screen
//   ldr_wr         in   1       loader write request, held until ldr_ack
//   ldr_idx        in   ADDR_W  loader address
//   ldr_wbyte      in   DATA_W  loader write data
//   ldr_ack        out  1       1-cycle completion pulse to loader
//   mem_read       out  1       to mem: read strobe
//   mem_read_idx   out  ADDR_W  to mem: read address
//   mem_read_byte  in   DATA_W  from mem: read data, valid with mem_read_ack
//   mem_read_ack   in   1       from mem: read done (1 cycle after mem_read)
//   mem_write      out  1       to mem: write strobe, committed at clk edge
//   mem_write_idx  out  ADDR_W  to mem: write address
//   mem_write_byte out  DATA_W  to mem: write data
//   timeout_err    out  1       sticky: a read hit GRANT_TMO; cleared by reset
// BEHAVIOUR
// - Reset: state IDLE, owner none, tmo counter 0, all acks 0, rbytes 0,
//   timeout_err 0; mem_read/mem_write 0 from the cycle after reset onward.
// - States: IDLE -> GRANT (registered owner + op) -> IDLE.
// - IDLE: if any request pending, pick winner (see CONFIGURATION), latch
//   owner, op (wr if owner's wr=1, else rd), addr, wdata; go GRANT. None -> stay.
// - GRANT/write: mem_write=1 for exactly one cycle with latched idx/byte;
//   owner ack pulses that same cycle; next state IDLE.
// - GRANT/read: mem_read=1 while !mem_read_ack; in mem_read_ack cycle copy
//   mem_read_byte to owner rbyte reg, pulse owner ack next cycle, go IDLE.
// - Latency: write req->ack 2 cycles; read req->ack 3 cycles (mem 1-cycle).
//   One IDLE cycle between consecutive grants (back-to-back max rate 1/2, 1/3).
// - mem_read and mem_write never both 1; mem idx/byte outputs 0 when unused.
// - cpu_rd & cpu_wr both 1: treated as write; read ignored.
// - Requester dropping request after grant: transaction still completes,
//   ack still pulses; requester must ignore it.
// - Timeout: counter counts GRANT/read cycles; at GRANT_TMO without ack,
//   drop mem_read, set timeout_err, pulse owner ack with rbyte=0, go IDLE.
// - Unused requester rbytes hold last value; acks only to owner.
// - Reset mid-transaction: abandon immediately, no ack emitted, no write issued
//   in the reset cycle.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin; priority rotates so the last winner
//   becomes lowest (order cpu->ldr->scr->cpu); reset pointer = cpu highest.
//   Undefined: fixed priority cpu > ldr > scr every IDLE decision.
// TESTING
// - Lone CPU write idx 0x020 byte 0x5A -> mem_write 1 cycle @0x020, cpu_ack
//   2 cycles after request, mem_read stays 0.
// - CPU read 0x200 (mem returns 0x6E) -> cpu_rbyte=0x6E with cpu_ack 3 cycles
//   after request; scr_ack/ldr_ack stay 0.
// - cpu_rd, scr_rd, ldr_wr same cycle, fixed prio -> grants cpu, ldr, scr;
//   RR_EN with scr held after ldr grant -> next grant scr even if cpu pending.
// - mem_read_ack tied 0, GRANT_TMO=15 -> mem_read high 15 cycles, then
//   timeout_err=1, cpu_ack pulse, cpu_rbyte=0; err persists until reset.
// - reset asserted in GRANT/read cycle -> no ack ever, mem_read 0 next cycle,
//   next request granted normally from IDLE.
// - cpu_rd=cpu_wr=1 idx 0x030 byte 0xF0 -> single write, no mem_read.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one read port and one write port of the memory between
// the CPU (read/write), the screen refresh reader (read-only) and the program
// loader (write-only). Only one transaction is in flight at a time.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration
// (cpu -> ldr -> scr -> cpu, last winner drops to lowest). When it is not
// defined, the priority is fixed: cpu > ldr > scr.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transaction; pick a winner from the pending requests
// ST_GRANT | owner latched; write completes here, or read waits for mem ack
module mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int GRANT_TMO = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_idx_i,
    input  logic [DATA_W-1:0] cpu_wbyte_i,
    output logic [DATA_W-1:0] cpu_rbyte_o,
    output logic              cpu_ack_o,
    input  logic              scr_rd_i,
    input  logic [ADDR_W-1:0] scr_idx_i,
    output logic [DATA_W-1:0] scr_rbyte_o,
    output logic              scr_ack_o,
    input  logic              ldr_wr_i,
    input  logic [ADDR_W-1:0] ldr_idx_i,
    input  logic [DATA_W-1:0] ldr_wbyte_i,
    output logic              ldr_ack_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_read_idx_o,
    input  logic [DATA_W-1:0] mem_read_byte_i,
    input  logic              mem_read_ack_i,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_write_idx_o,
    output logic [DATA_W-1:0] mem_write_byte_o,
    output logic              timeout_err_o
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2,
        OWN_SCR  = 2'd3
    } owner_t;

    state_t            state_q;
    owner_t            owner_q;
    owner_t            win_d;
    logic              is_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        tmo_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              cpu_ack_q;
    logic              scr_ack_q;
    logic              ldr_ack_q;
    logic [DATA_W-1:0] cpu_rbyte_q;
    logic [DATA_W-1:0] scr_rbyte_q;
    logic              timeout_err_q;
    logic              cpu_req;
    logic              grant_done;
    logic              tmo_hit;
    logic [DATA_W-1:0] rdata_d;

    // A simultaneous read and write from the CPU is handled as a write.
    assign cpu_req = cpu_rd_i | cpu_wr_i;

`ifdef MEM_ARB_RR_EN
    owner_t rr_hi_q;

    // Choose the winner starting from the requester that currently has top priority.
    always_comb begin
        win_d = OWN_NONE;
        case (rr_hi_q)
            OWN_LDR: begin
                if (ldr_wr_i)      win_d = OWN_LDR;
                else if (scr_rd_i) win_d = OWN_SCR;
                else if (cpu_req)  win_d = OWN_CPU;
            end
            OWN_SCR: begin
                if (scr_rd_i)      win_d = OWN_SCR;
                else if (cpu_req)  win_d = OWN_CPU;
                else if (ldr_wr_i) win_d = OWN_LDR;
            end
            default: begin
                if (cpu_req)       win_d = OWN_CPU;
                else if (ldr_wr_i) win_d = OWN_LDR;
                else if (scr_rd_i) win_d = OWN_SCR;
            end
        endcase
    end

    // Rotate priority on every grant so the winner becomes lowest next time.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_hi_q <= OWN_CPU;
        end else if (state_q == ST_IDLE) begin
            case (win_d)
                OWN_CPU: rr_hi_q <= OWN_LDR;
                OWN_LDR: rr_hi_q <= OWN_SCR;
                OWN_SCR: rr_hi_q <= OWN_CPU;
                default: rr_hi_q <= rr_hi_q;
            endcase
        end
    end
`else
    // Fixed priority: cpu first, then loader, then screen.
    always_comb begin
        win_d = OWN_NONE;
        if (cpu_req)       win_d = OWN_CPU;
        else if (ldr_wr_i) win_d = OWN_LDR;
        else if (scr_rd_i) win_d = OWN_SCR;
    end
`endif

    // Decide whether the granted transaction finishes this cycle and with which data.
    always_comb begin
        grant_done = 1'b0;
        tmo_hit    = 1'b0;
        rdata_d    = mem_read_byte_i;
        if (state_q == ST_GRANT) begin
            if (is_wr_q || mem_read_ack_i) begin
                grant_done = 1'b1;
            end else if (tmo_q == 8'd0) begin
                grant_done = 1'b1;
                tmo_hit    = 1'b1;
                rdata_d    = '0;
            end
        end
    end

    // Main FSM: latch the winner, run its transaction, pulse the owner's ack.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_NONE;
            is_wr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tmo_q         <= 8'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            scr_ack_q     <= 1'b0;
            ldr_ack_q     <= 1'b0;
            cpu_rbyte_q   <= '0;
            scr_rbyte_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cpu_ack_q   <= 1'b0;
            scr_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_d != OWN_NONE) begin
                        state_q <= ST_GRANT;
                        owner_q <= win_d;
                        case (win_d)
                            OWN_CPU: begin
                                is_wr_q <= cpu_wr_i;
                                addr_q  <= cpu_idx_i;
                                wdata_q <= cpu_wbyte_i;
                            end
                            OWN_LDR: begin
                                is_wr_q <= 1'b1;
                                addr_q  <= ldr_idx_i;
                                wdata_q <= ldr_wbyte_i;
                            end
                            default: begin
                                is_wr_q <= 1'b0;
                                addr_q  <= scr_idx_i;
                                wdata_q <= '0;
                            end
                        endcase
                        // Read strobe starts with the grant so a 1-cycle memory acks in the next cycle.
                        mem_read_q <= !(win_d == OWN_LDR || (win_d == OWN_CPU && cpu_wr_i));
                        tmo_q      <= 8'(GRANT_TMO - 1);
                    end
                end
                ST_GRANT: begin
                    if (grant_done) begin
                        state_q       <= ST_IDLE;
                        owner_q       <= OWN_NONE;
                        mem_read_q    <= 1'b0;
                        mem_write_q   <= is_wr_q;
                        tmo_q         <= 8'd0;
                        timeout_err_q <= timeout_err_q | tmo_hit;
                        case (owner_q)
                            OWN_CPU: begin
                                cpu_ack_q <= 1'b1;
                                if (!is_wr_q) cpu_rbyte_q <= rdata_d;
                            end
                            OWN_SCR: begin
                                scr_ack_q   <= 1'b1;
                                scr_rbyte_q <= rdata_d;
                            end
                            OWN_LDR: ldr_ack_q <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The read strobe drops as soon as the memory acks; the write strobe is
    // suppressed while reset is held so nothing commits on the reset edge.
    assign mem_read_o       = mem_read_q & ~mem_read_ack_i;
    assign mem_read_idx_o   = mem_read_o ? addr_q : '0;
    assign mem_write_o      = mem_write_q & ~reset_i;
    assign mem_write_idx_o  = mem_write_o ? addr_q : '0;
    assign mem_write_byte_o = mem_write_o ? wdata_q : '0;
    assign cpu_ack_o        = cpu_ack_q;
    assign scr_ack_o        = scr_ack_q;
    assign ldr_ack_o        = ldr_ack_q;
    assign cpu_rbyte_o      = cpu_rbyte_q;
    assign scr_rbyte_o      = scr_rbyte_q;
    assign timeout_err_o    = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a vector table of single transactions, a scoreboard
// of expected acks in grant order, a 1-cycle memory model, and hand-written
// sequences for contention, timeout and reset mid-transaction.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr, scr_rd, ldr_wr;
    logic [AW-1:0] cpu_idx, scr_idx, ldr_idx;
    logic [DW-1:0] cpu_wbyte, ldr_wbyte, cpu_rbyte, scr_rbyte;
    logic          cpu_ack, scr_ack, ldr_ack;
    logic          mem_read, mem_write, mem_rack;
    logic [AW-1:0] mem_read_idx, mem_write_idx;
    logic [DW-1:0] mem_rbyte, mem_write_byte;
    logic          timeout_err;
    logic          mem_ack_en;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GRANT_TMO(15)) dut (
        .clk_i(clk), .reset_i(reset),
        .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_idx_i(cpu_idx),
        .cpu_wbyte_i(cpu_wbyte), .cpu_rbyte_o(cpu_rbyte), .cpu_ack_o(cpu_ack),
        .scr_rd_i(scr_rd), .scr_idx_i(scr_idx), .scr_rbyte_o(scr_rbyte), .scr_ack_o(scr_ack),
        .ldr_wr_i(ldr_wr), .ldr_idx_i(ldr_idx), .ldr_wbyte_i(ldr_wbyte), .ldr_ack_o(ldr_ack),
        .mem_read_o(mem_read), .mem_read_idx_o(mem_read_idx),
        .mem_read_byte_i(mem_rbyte), .mem_read_ack_i(mem_rack),
        .mem_write_o(mem_write), .mem_write_idx_o(mem_write_idx),
        .mem_write_byte_o(mem_write_byte), .timeout_err_o(timeout_err)
    );

    int checks   = 0;
    int failures = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int overlap   = 0;

    typedef struct {
        int         who;
        bit         is_rd;
        logic [7:0] rbyte;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int         kind;
        logic [11:0] idx;
        logic [7:0] wb;
        int         lat;
        logic [7:0] rb;
    } vec_t;
    vec_t vecs[12];

    logic [7:0] mem [0:4095];

    // Memory model: preload, then commit writes at the edge and answer reads one cycle later.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 3 + 1);
        mem[12'h200] = 8'h6E;
        mem[12'h040] = 8'h44;
        mem_rack  = 1'b0;
        mem_rbyte = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_write_idx] <= mem_write_byte;
            mem_rack  <= mem_ack_en & mem_read;
            mem_rbyte <= mem[mem_read_idx];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int who, input logic [7:0] rb);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack actual_who=%0d expected=no_ack", who);
            return;
        end
        e = sb_q.pop_front();
        if (e.who != who) begin
            failures++;
            $display("FAIL ack_owner actual_who=%0d expected_who=%0d", who, e.who);
        end else if (e.is_rd) begin
            checks++;
            if (rb !== e.rbyte) begin
                failures++;
                $display("FAIL rbyte who=%0d actual=0x%0h expected=0x%0h", who, rb, e.rbyte);
            end
        end
    endtask

    // Monitor: strobe counters and scoreboard check on every ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_read) rd_cycles++;
            if (mem_write) wr_cycles++;
            if (mem_read && mem_write) overlap++;
            if (cpu_ack) sb_pop(0, cpu_rbyte);
            if (scr_ack) sb_pop(1, scr_rbyte);
            if (ldr_ack) sb_pop(2, 8'h00);
        end
    end

    function automatic int who_of(input int kind);
        if (kind <= 2) return 0;
        if (kind == 3) return 1;
        return 2;
    endfunction

    function automatic logic ack_of(input int kind);
        if (kind <= 2) return cpu_ack;
        if (kind == 3) return scr_ack;
        return ldr_ack;
    endfunction

    // kind: 0 cpu rd, 1 cpu wr, 2 cpu rd+wr, 3 scr rd, 4 ldr wr; exp_lat 0 = no latency check
    task automatic issue(input int kind, input logic [11:0] idx, input logic [7:0] wb, input int exp_lat);
        int n;
        bit got;
        @(negedge clk);
        case (kind)
            0: begin cpu_rd = 1'b1; cpu_idx = idx; end
            1: begin cpu_wr = 1'b1; cpu_idx = idx; cpu_wbyte = wb; end
            2: begin cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_idx = idx; cpu_wbyte = wb; end
            3: begin scr_rd = 1'b1; scr_idx = idx; end
            default: begin ldr_wr = 1'b1; ldr_idx = idx; ldr_wbyte = wb; end
        endcase
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            got = ack_of(kind);
        end
        case (kind)
            0: cpu_rd = 1'b0;
            1: cpu_wr = 1'b0;
            2: begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
            3: scr_rd = 1'b0;
            default: ldr_wr = 1'b0;
        endcase
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_wait kind=%0d actual=no_ack_in_%0d_cycles expected=ack", kind, n);
        end
        if (got && exp_lat > 0) begin
            checks++;
            if (n != exp_lat) begin
                failures++;
                $display("FAIL latency kind=%0d actual=%0d expected=%0d", kind, n, exp_lat);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd;
        int lat_cpu, lat_scr;

        vecs[0]  = '{1, 12'h020, 8'h5A, 2, 8'h00};
        vecs[1]  = '{0, 12'h200, 8'h00, 3, 8'h6E};
        vecs[2]  = '{0, 12'h020, 8'h00, 3, 8'h5A};
        vecs[3]  = '{3, 12'h200, 8'h00, 3, 8'h6E};
        vecs[4]  = '{4, 12'h7FF, 8'h33, 2, 8'h00};
        vecs[5]  = '{3, 12'h7FF, 8'h00, 3, 8'h33};
        vecs[6]  = '{2, 12'h030, 8'hF0, 2, 8'h00};
        vecs[7]  = '{0, 12'h030, 8'h00, 3, 8'hF0};
        vecs[8]  = '{1, 12'hFFF, 8'hC3, 2, 8'h00};
        vecs[9]  = '{0, 12'hFFF, 8'h00, 3, 8'hC3};
        vecs[10] = '{4, 12'h000, 8'h01, 2, 8'h00};
        vecs[11] = '{3, 12'h000, 8'h00, 3, 8'h01};

        reset = 1'b1;
        cpu_rd = 0; cpu_wr = 0; scr_rd = 0; ldr_wr = 0;
        cpu_idx = 0; scr_idx = 0; ldr_idx = 0; cpu_wbyte = 0; ldr_wbyte = 0;
        mem_ack_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_scr_ack", scr_ack, 0);
        chk("rst_ldr_ack", ldr_ack, 0);
        chk("rst_cpu_rbyte", cpu_rbyte, 0);
        chk("rst_scr_rbyte", scr_rbyte, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);

        for (int i = 0; i < 12; i++) begin
            rd = (vecs[i].kind == 0 || vecs[i].kind == 3);
            rd_cycles = 0;
            wr_cycles = 0;
            sb_q.push_back('{who_of(vecs[i].kind), rd, vecs[i].rb});
            issue(vecs[i].kind, vecs[i].idx, vecs[i].wb, vecs[i].lat);
            @(posedge clk);
            @(negedge clk);
            if (rd) begin
                chk("vec_rd_strobes", rd_cycles, 1);
                chk("vec_wr_strobes", wr_cycles, 0);
            end else begin
                chk("vec_wr_strobes", wr_cycles, 1);
                chk("vec_rd_strobes", rd_cycles, 0);
                chk("vec_mem_content", mem[vecs[i].idx], vecs[i].wb);
            end
        end
        chk("no_timeout_yet", timeout_err, 0);

        // All three request in the same cycle, starting from reset priority.
        do_reset();
        sb_q.push_back('{0, 1'b1, 8'h6E});
        sb_q.push_back('{2, 1'b0, 8'h00});
        sb_q.push_back('{1, 1'b1, 8'h33});
        fork
            issue(0, 12'h200, 8'h00, 3);
            issue(4, 12'h100, 8'h77, 5);
            issue(3, 12'h7FF, 8'h00, 8);
        join

        // Loader alone, then cpu and screen together: round-robin favours screen.
        sb_q.push_back('{2, 1'b0, 8'h00});
        issue(4, 12'h101, 8'h55, 2);
`ifdef MEM_ARB_RR_EN
        lat_scr = 3;
        lat_cpu = 6;
        sb_q.push_back('{1, 1'b1, 8'h77});
        sb_q.push_back('{0, 1'b1, 8'h55});
`else
        lat_cpu = 3;
        lat_scr = 6;
        sb_q.push_back('{0, 1'b1, 8'h55});
        sb_q.push_back('{1, 1'b1, 8'h77});
`endif
        fork
            issue(0, 12'h101, 8'h00, lat_cpu);
            issue(3, 12'h100, 8'h00, lat_scr);
        join

        // Memory never acks: read aborts after 15 strobe cycles.
        mem_ack_en = 1'b0;
        rd_cycles = 0;
        sb_q.push_back('{0, 1'b1, 8'h00});
        issue(0, 12'h200, 8'h00, 16);
        @(negedge clk);
        chk("tmo_rd_strobes", rd_cycles, 15);
        chk("tmo_err_set", timeout_err, 1);
        mem_ack_en = 1'b1;
        sb_q.push_back('{0, 1'b1, 8'h6E});
        issue(0, 12'h200, 8'h00, 3);
        chk("tmo_err_sticky", timeout_err, 1);

        do_reset();
        chk("tmo_err_cleared", timeout_err, 0);

        // Reset during a read grant: no ack, strobe gone after the reset edge.
        mem_ack_en = 1'b0;
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_idx = 12'h100;
        @(posedge clk);
        @(negedge clk);
        chk("midrd_strobe", mem_read, 1);
        reset = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clk);
        #1;
        chk("midrd_strobe_after_reset", mem_read, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        mem_ack_en = 1'b1;
        sb_q.push_back('{0, 1'b1, 8'h6E});
        issue(0, 12'h200, 8'h00, 3);

        // Reset during a write grant: the write never reaches memory.
        wr_cycles = 0;
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_idx = 12'h040;
        cpu_wbyte = 8'h99;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cpu_wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midwr_no_strobe", wr_cycles, 0);
        chk("midwr_mem_kept", mem[12'h040], 8'h44);
        sb_q.push_back('{0, 1'b0, 8'h00});
        issue(1, 12'h040, 8'h99, 2);
        @(posedge clk);
        @(negedge clk);
        chk("postwr_mem", mem[12'h040], 8'h99);

        repeat (2) @(negedge clk);
        chk("rd_wr_overlap", overlap, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
